// File: rtl/image_encrypter_seq_if.sv
// Valid/ready plaintext offer and done-pulsed ciphertext return between the
// encryption sequencer (master) and an external 128-bit block-cipher core (slave).
interface image_encrypter_seq_if;
    logic         core_valid;
    logic         core_ready;
    logic [127:0] core_pt;
    logic         core_done;
    logic [127:0] core_ct;

    modport master (
        output core_valid,
        output core_pt,
        input  core_ready,
        input  core_done,
        input  core_ct
    );

    modport slave (
        input  core_valid,
        input  core_pt,
        output core_ready,
        output core_done,
        output core_ct
    );
endinterface

// File: rtl/image_encrypter_seq.sv
// Walks a plaintext image 16 bytes at a time, runs each block through an external cipher
// core and writes the ciphertext back at the same addresses. Define CBC_EN for CBC chaining.
module image_encrypter_seq #(
    parameter int unsigned  ADDR_W    = 15,
    parameter int unsigned  IMG_BYTES = 19200,
    parameter logic [127:0] IV        = 128'h0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [7:0]          rd_data,
    image_encrypter_seq_if.master core,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [7:0]          wr_data,
    output logic                wr_en,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-5:0]   blk_count
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StIssue,
        StWait,
        StStore,
        StFinish
    } state_e;

    localparam int unsigned     AW1    = ADDR_W + 1;
    localparam logic [ADDR_W:0] ImgEnd = AW1'(IMG_BYTES);

    state_e              r_state;
    logic [4:0]          r_k;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [7:0]          r_wr_data;
    logic                r_wr_en;
    logic                r_core_valid;
    logic [127:0]        r_core_pt;
    logic                r_busy;
    logic                r_done;
    logic [ADDR_W-5:0]   r_blk_count;
    // Byte shift registers: newest byte enters at the bottom, byte 0 ends up on top.
    logic [119:0]        r_blk;
    logic [119:0]        r_ct;

    logic [127:0]        w_gathered;
    logic [127:0]        w_chain;
    logic [ADDR_W-1:0]   w_base_next;
    logic                w_last;

`ifdef CBC_EN
    logic [127:0]        r_chain;
    assign w_chain = r_chain;
`else
    assign w_chain = 128'h0;
`endif

    assign w_gathered  = {r_blk, rd_data};
    assign w_base_next = r_base + ADDR_W'(16);
    assign w_last      = ({1'b0, r_base} + AW1'(16)) == ImgEnd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= StIdle;
            r_k          <= '0;
            r_base       <= '0;
            r_rd_addr    <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_wr_en      <= 1'b0;
            r_core_valid <= 1'b0;
            r_core_pt    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_blk_count  <= '0;
            r_blk        <= '0;
            r_ct         <= '0;
`ifdef CBC_EN
            r_chain      <= IV;
`endif
        end else begin
            unique case (r_state)
                StIdle, StFinish: begin
                    if (start) begin
                        r_state     <= StFetch;
                        r_base      <= '0;
                        r_rd_addr   <= '0;
                        r_k         <= '0;
                        r_blk_count <= '0;
                        r_done      <= 1'b0;
                        r_busy      <= 1'b1;
`ifdef CBC_EN
                        r_chain     <= IV;
`endif
                    end
                end
                StFetch: begin
                    // rd_data lags rd_addr by one cycle, so cycles 1..16 carry bytes 0..15.
                    if (r_k != 5'd0) r_blk <= w_gathered[119:0];
                    if (r_k < 5'd15) r_rd_addr <= r_rd_addr + ADDR_W'(1);
                    if (r_k == 5'd16) begin
                        r_state      <= StIssue;
                        r_core_valid <= 1'b1;
                        r_core_pt    <= w_gathered ^ w_chain;
                        r_k          <= '0;
                    end else begin
                        r_k <= r_k + 5'd1;
                    end
                end
                StIssue: begin
                    if (core.core_ready) begin
                        r_core_valid <= 1'b0;
                        r_state      <= StWait;
                    end
                end
                StWait: begin
                    if (core.core_done) begin
                        r_state   <= StStore;
                        r_ct      <= core.core_ct[119:0];
                        r_wr_data <= core.core_ct[127:120];
                        r_wr_addr <= r_base;
                        r_wr_en   <= 1'b1;
                        r_k       <= '0;
`ifdef CBC_EN
                        r_chain   <= core.core_ct;
`endif
                    end
                end
                StStore: begin
                    if (r_k == 5'd15) begin
                        r_wr_en     <= 1'b0;
                        r_blk_count <= r_blk_count + 1'b1;
                        r_base      <= w_base_next;
                        r_k         <= '0;
                        if (w_last) begin
                            r_state <= StFinish;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= StFetch;
                            r_rd_addr <= w_base_next;
                        end
                    end else begin
                        r_k       <= r_k + 5'd1;
                        r_wr_addr <= r_wr_addr + ADDR_W'(1);
                        r_wr_data <= r_ct[119:112];
                        r_ct      <= {r_ct[111:0], 8'h00};
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign rd_addr         = r_rd_addr;
    assign wr_addr         = r_wr_addr;
    assign wr_data         = r_wr_data;
    assign wr_en           = r_wr_en;
    assign busy            = r_busy;
    assign done            = r_done;
    assign blk_count       = r_blk_count;
    assign core.core_valid = r_core_valid;
    assign core.core_pt    = r_core_pt;

endmodule

// File: tb/tb_image_encrypter_seq.sv
// Self-checking bench for image_encrypter_seq: byte memories, a cipher-core model and an
// image-level reference computed block by block from the plaintext.
module tb_image_encrypter_seq;

`ifdef CBC_EN
    localparam int IMG = 48;
`else
    localparam int IMG = 32;
`endif
    localparam int NBLK = IMG / 16;
    localparam int AW   = 15;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [AW-1:0]  rd_addr;
    logic [7:0]     rd_data;
    logic [AW-1:0]  wr_addr;
    logic [7:0]     wr_data;
    logic           wr_en;
    logic           busy;
    logic           done;
    logic [AW-5:0]  blk_count;

    image_encrypter_seq_if cif ();

    image_encrypter_seq #(
        .ADDR_W    (AW),
        .IMG_BYTES (IMG),
        .IV        (128'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .core      (cif),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .busy      (busy),
        .done      (done),
        .blk_count (blk_count)
    );

    always #5 clk = ~clk;

    logic [7:0] src_mem [IMG];
    logic [7:0] dst_mem [IMG];
    logic [7:0] exp_mem [IMG];
    logic [127:0] exp_pt0;

    int n_cmp = 0;
    int n_bad = 0;

    // Core model and monitor controls (each written only by the initial block).
    logic [7:0] key = 8'hA5;
    int         stall_cfg = 0;
    logic       stats_clr = 1'b0;
    logic       dst_clr = 1'b0;
    logic       spur_done = 1'b0;

    // Model and monitor state (written only by the clocked block below).
    logic         m_done = 1'b0;
    logic [127:0] m_ct = '0;
    int           stall_left = 0;
    int           xfer = 0;
    int           vcyc = 0;
    int           wr_cnt = 0;
    bit           pt_changed = 1'b0;
    bit           wr_bad = 1'b0;
    logic         prev_valid = 1'b0;
    logic [127:0] prev_pt = '0;
    logic [127:0] first_pt = '0;

    assign cif.core_ready = (stall_left == 0);
    assign cif.core_done  = m_done | spur_done;
    assign cif.core_ct    = spur_done ? 128'hDEAD_BEEF_0BAD_F00D_DEAD_BEEF_0BAD_F00D : m_ct;

    always @(posedge clk) begin
        rd_data <= (int'(rd_addr) < IMG) ? src_mem[rd_addr] : 8'h00;
        if (dst_clr) begin
            for (int i = 0; i < IMG; i++) dst_mem[i] <= 8'hEE;
        end else if (wr_en && int'(wr_addr) < IMG) begin
            dst_mem[wr_addr] <= wr_data;
        end
    end

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (cif.core_valid && cif.core_ready) begin
            m_done <= 1'b1;
            m_ct   <= cif.core_pt ^ {16{key}};
        end
        if (stats_clr) begin
            stall_left <= stall_cfg;
            xfer       <= 0;
            vcyc       <= 0;
            wr_cnt     <= 0;
            pt_changed <= 1'b0;
            wr_bad     <= 1'b0;
        end else begin
            if (cif.core_valid && cif.core_ready) begin
                if (xfer == 0) first_pt <= cif.core_pt;
                xfer <= xfer + 1;
            end
            if (cif.core_valid && !cif.core_ready && stall_left != 0) stall_left <= stall_left - 1;
            if (cif.core_valid) vcyc <= vcyc + 1;
            if (cif.core_valid && prev_valid && cif.core_pt != prev_pt) pt_changed <= 1'b1;
            if (wr_en) begin
                wr_cnt <= wr_cnt + 1;
                if (!busy) wr_bad <= 1'b1;
            end
        end
        prev_valid <= cif.core_valid;
        prev_pt    <= cif.core_pt;
    end

    // Reference: gather 16 plaintext bytes (byte 0 most significant), optionally chain,
    // encrypt with the XOR core, then spread the ciphertext back over the same addresses.
    task automatic build_expected();
        logic [127:0] pt, ct, chain;
        chain = 128'h0;
        for (int b = 0; b < NBLK; b++) begin
            pt = '0;
            for (int j = 0; j < 16; j++) pt = {pt[119:0], src_mem[b*16+j]};
`ifdef CBC_EN
            pt = pt ^ chain;
`endif
            if (b == 0) exp_pt0 = pt;
            ct = pt ^ {16{key}};
            chain = ct;
            for (int j = 0; j < 16; j++) exp_mem[b*16+j] = ct[127-8*j -: 8];
        end
    endtask

    function automatic int bad_bytes();
        int n = 0;
        for (int i = 0; i < IMG; i++) if (dst_mem[i] !== exp_mem[i]) n++;
        return n;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < IMG; i++) src_mem[i] = 8'($urandom);
    endtask

    task automatic prep_run(input int stall);
        stall_cfg = stall;
        stats_clr = 1'b1;
        dst_clr   = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        dst_clr   = 1'b0;
        build_expected();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({rd_addr, wr_addr, wr_data, wr_en, cif.core_valid, busy, done, blk_count} !== '0
            || cif.core_pt !== 128'h0) begin
            n_bad++;
            $display("FAIL reset_values: rd=%h wr=%h wd=%h we=%b v=%b pt=%h busy=%b done=%b bc=%0d, required all zero",
                     rd_addr, wr_addr, wr_data, wr_en, cif.core_valid, cif.core_pt, busy, done,
                     blk_count);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ecb_basic();
        bit ok;
        int nb;
        for (int i = 0; i < IMG; i++) src_mem[i] = 8'(i);
        key = 8'hA5;
        prep_run(0);
        pulse_start();
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b need 1", busy); end
        wait_done(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL basic_timeout: done=%b need 1", done); end
        nb = bad_bytes();
        n_cmp++;
        if (nb !== 0) begin n_bad++; $display("FAIL basic_bytes: %0d wrong bytes, need 0", nb); end
        n_cmp++;
        if (blk_count !== (AW-4)'(NBLK) || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_count: bc=%0d busy=%b need bc=%0d busy=0", blk_count, busy, NBLK);
        end
        n_cmp++;
        if (first_pt !== exp_pt0) begin
            n_bad++;
            $display("FAIL basic_pt0: got %h need %h", first_pt, exp_pt0);
        end
        n_cmp++;
        if (wr_cnt !== IMG || wr_bad) begin
            n_bad++;
            $display("FAIL basic_writes: got %0d (stray=%b) need %0d", wr_cnt, wr_bad, IMG);
        end
    endtask

    task automatic test_stall();
        bit ok;
        int nb;
        fill_random();
        key = 8'($urandom);
        prep_run(10);
        pulse_start();
        wait_done(ok);
        nb = bad_bytes();
        n_cmp++;
        if (!ok || nb !== 0) begin
            n_bad++;
            $display("FAIL stall_bytes: done=%b wrong=%0d need done=1 wrong=0", ok, nb);
        end
        n_cmp++;
        if (vcyc !== 11 + (NBLK - 1) || pt_changed) begin
            n_bad++;
            $display("FAIL stall_valid: cycles=%0d pt_changed=%b need %0d and 0",
                     vcyc, pt_changed, 11 + (NBLK - 1));
        end
        n_cmp++;
        if (xfer !== NBLK) begin
            n_bad++;
            $display("FAIL stall_xfer: got %0d need %0d", xfer, NBLK);
        end
    endtask

    task automatic test_start_ignored();
        bit ok;
        int nb;
        fill_random();
        key = 8'($urandom);
        prep_run(0);
        pulse_start();
        ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (blk_count == 1) begin ok = 1'b1; break; end
        end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL busy_block1: bc=%0d need 1", blk_count); end
        repeat (3) @(negedge clk);
        pulse_start();
        wait_done(ok);
        nb = bad_bytes();
        n_cmp++;
        if (!ok || nb !== 0 || xfer !== NBLK || blk_count !== (AW-4)'(NBLK)) begin
            n_bad++;
            $display("FAIL busy_start: done=%b wrong=%0d xfer=%0d bc=%0d need 1/0/%0d/%0d",
                     ok, nb, xfer, blk_count, NBLK, NBLK);
        end
        prep_run(0);
        pulse_start();
        n_cmp++;
        if (done !== 1'b0 || blk_count !== '0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_clear: done=%b bc=%0d busy=%b need 0/0/1", done, blk_count, busy);
        end
        wait_done(ok);
        nb = bad_bytes();
        n_cmp++;
        if (!ok || nb !== 0 || wr_cnt !== IMG || blk_count !== (AW-4)'(NBLK)) begin
            n_bad++;
            $display("FAIL restart_run: done=%b wrong=%0d writes=%0d bc=%0d need 1/0/%0d/%0d",
                     ok, nb, wr_cnt, blk_count, IMG, NBLK);
        end
    endtask

    task automatic test_spurious();
        bit ok;
        int nb;
        fill_random();
        key = 8'($urandom);
        prep_run(3);
        pulse_start();
        repeat (3) @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (cif.core_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        n_cmp++;
        if (!ok || wr_en !== 1'b0 || wr_cnt !== 0) begin
            n_bad++;
            $display("FAIL spur_nowrite: issue_seen=%b we=%b writes=%0d need 1/0/0", ok, wr_en, wr_cnt);
        end
        wait_done(ok);
        nb = bad_bytes();
        n_cmp++;
        if (!ok || nb !== 0 || wr_cnt !== IMG) begin
            n_bad++;
            $display("FAIL spur_bytes: done=%b wrong=%0d writes=%0d need 1/0/%0d", ok, nb, wr_cnt, IMG);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int nb;
        fill_random();
        key = 8'($urandom);
        prep_run(0);
        pulse_start();
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (wr_en && wr_addr == 5) begin ok = 1'b1; break; end
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (!ok || wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || blk_count !== '0
            || rd_addr !== '0 || wr_addr !== '0 || wr_data !== '0 || cif.core_valid !== 1'b0
            || cif.core_pt !== 128'h0) begin
            n_bad++;
            $display("FAIL midreset_values: seen=%b we=%b busy=%b done=%b bc=%0d rd=%h wr=%h wd=%h v=%b, required zeros",
                     ok, wr_en, busy, done, blk_count, rd_addr, wr_addr, wr_data, cif.core_valid);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (wr_cnt !== 5) begin
            n_bad++;
            $display("FAIL midreset_abort: writes=%0d need 5", wr_cnt);
        end
        rst = 1'b1;
        @(negedge clk);
        prep_run(0);
        pulse_start();
        wait_done(ok);
        nb = bad_bytes();
        n_cmp++;
        if (!ok || nb !== 0 || wr_cnt !== IMG) begin
            n_bad++;
            $display("FAIL midreset_rerun: done=%b wrong=%0d writes=%0d need 1/0/%0d", ok, nb, wr_cnt, IMG);
        end
    endtask

`ifdef CBC_EN
    task automatic test_cbc();
        bit ok;
        int nb;
        for (int i = 0; i < IMG; i++) src_mem[i] = 8'h11;
        key = 8'h00;
        prep_run(0);
        pulse_start();
        wait_done(ok);
        nb = bad_bytes();
        n_cmp++;
        if (!ok || nb !== 0) begin
            n_bad++;
            $display("FAIL cbc_bytes: done=%b wrong=%0d need 1/0", ok, nb);
        end
        n_cmp++;
        if (dst_mem[0] !== 8'h11 || dst_mem[16] !== 8'h00 || dst_mem[32] !== 8'h11) begin
            n_bad++;
            $display("FAIL cbc_pattern: got %h %h %h need 11 00 11", dst_mem[0], dst_mem[16], dst_mem[32]);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < IMG; i++) src_mem[i] = 8'h00;
        test_reset();
        test_ecb_basic();
        test_stall();
        test_start_ignored();
        test_spurious();
        test_reset_mid();
        for (int r = 0; r < 3; r++) test_stall();
`ifdef CBC_EN
        test_cbc();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/image_encrypter_seq.md
Name: image_encrypter_seq

Overview:
Encryption-side sequencer, the write-direction counterpart of the on-board image decrypter. It walks a plaintext image memory 16 bytes at a time and packs each group into a 128-bit block. It hands each block to an external 128-bit block-cipher core over a valid/ready handshake, then writes the returned ciphertext bytes to a destination image memory at the same addresses. This lets the board produce encrypted images that the display path can later decrypt and show.

Parameters:
ADDR_W, 15, width of source/destination byte address (matches image memories).
IMG_BYTES, 19200, number of image bytes processed per run. Must be a nonzero multiple of 16 and <= 2^ADDR_W.
IV, 128'h0, initial chaining value (used only when CBC_EN is defined).

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  asynchronous, active-low reset.
start  in  1  one-cycle request to begin a run; sampled only in IDLE or FINISH.
rd_addr  out  ADDR_W  plaintext memory read address.
rd_data  in  8  plaintext byte; synchronous memory, valid exactly 1 cycle after rd_addr.
core_valid  out  1  plaintext block offered to the cipher core.
core_ready  in  1  core accepts the block when core_valid && core_ready.
core_pt  out  128  plaintext block; byte 0 of the group in bits [127:120].
core_done  in  1  one-cycle pulse: core_ct is valid.
core_ct  in  128  ciphertext block, same byte order as core_pt.
wr_addr  out  ADDR_W  destination memory write address.
wr_data  out  8  destination byte.
wr_en  out  1  write strobe, one byte per cycle.
busy  out  1  high from the cycle after start is accepted until FINISH is entered.
done  out  1  high in FINISH; held until the next accepted start or reset.
blk_count  out  ADDR_W-4  number of blocks fully stored in the current run.

Behaviour:
- Reset (rst low, asynchronous) gives: state IDLE, rd_addr=0, wr_addr=0, wr_data=0, wr_en=0, core_valid=0, core_pt=0, busy=0, done=0, blk_count=0, base=0, chain register=IV. Reset mid-run aborts immediately; no partial write completes after reset asserts.
- States: IDLE, FETCH, ISSUE, WAIT, STORE, FINISH.
- IDLE/FINISH: start=1 -> FETCH; base=0, blk_count=0, done=0, busy=1, chain=IV.
- FETCH: runs 17 cycles.
  - Cycles k=0..15 drive rd_addr=base+k.
  - Cycles k=1..16 capture rd_data into byte k-1 of the block register.
  - After cycle 16 -> ISSUE.
- ISSUE: core_valid=1 and core_pt stays stable until the handshake cycle (core_valid && core_ready). On that edge, core_valid drops to 0 and the state goes to WAIT. If core_ready is already high on the first ISSUE cycle, the transfer takes one cycle.
- WAIT: on core_done=1, capture core_ct and go to STORE. core_done in any other state is ignored. There is no timeout.
- STORE: 16 consecutive cycles with wr_en=1, wr_addr=base+k, wr_data=ct byte k (k=0..15). On the last store edge: blk_count+=1 and base+=16.
  - If base+16==IMG_BYTES -> FINISH (busy=0, done=1).
  - Otherwise -> FETCH.
- Address arithmetic is modulo 2^ADDR_W. No wrap occurs for legal IMG_BYTES; the final block ends at IMG_BYTES-1.
- start while busy is ignored. start in FINISH restarts a full run from address 0.
- Minimum per-block latency with core_ready=1 and core_done one cycle after acceptance: 17+1+1+16 = 35 cycles.
- wr_en is never high outside STORE. rd_addr holds its last value outside FETCH.

Optional Feature:
CBC_EN. When defined, core_pt = gathered block XOR chain; chain loads core_ct on each WAIT->STORE transition and is reset to IV on start or reset. When not defined, ECB mode applies: core_pt = gathered block, and the chain register is not instantiated.

Test Plan:
- Reset during STORE (k=5), then release -> all outputs at reset values, wr_en=0 the same cycle; a fresh start with IMG_BYTES=32 writes 32 correct bytes from address 0.
- IMG_BYTES=32, ECB; plaintext mem[i]=i; core model returns ct=pt XOR {16{8'hA5}} with ready=1 and done one cycle after acceptance -> dest[i]=i^8'hA5 for i=0..31, done=1, blk_count=2, block 0 core_pt=128'h000102...0F.
- Same setup with core_ready held low for 10 ISSUE cycles -> core_valid high for 11 cycles with core_pt unchanged throughout; exactly one transfer; output unchanged.
- start pulsed during FETCH of block 1 and again in FINISH -> first pulse ignored (run not restarted, blk_count continues); second pulse clears done, blk_count=0, run repeats identically.
- Spurious core_done pulses in FETCH and ISSUE -> ignored; no wr_en, ct not captured; the real done in WAIT stores the correct bytes.
- CBC_EN, IV=0, identity core (ct=pt), plaintext all 8'h11, IMG_BYTES=48 -> blocks 0,1,2 store 8'h11, 8'h00, 8'h11 respectively.
